// File: rtl/branch_ctrl_fsm.sv
// branch_ctrl_fsm
//   Multicycle sub-FSM beside the main control unit that owns branch and
//   jump instructions (beq/bne/ble/bgt/j/jal). The main FSM hands over with a
//   one-cycle start after decode; this block drives the ALU, PC-source and
//   PC-write enables, then returns a one-cycle done.
//
//   Optional build macro: BRANCH_JAL_EN
//     defined     : opcode 0x03 (jal) runs IDLE -> LINK -> JUMP
//     not defined : LINK is not built, 0x03 is illegal, link_write tied to 0
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   start          one-cycle request, sampled only in IDLE
//   opcode         instruction opcode, valid with start
//   branch_ctrl    condition select: 00 gt, 01 not_gt, 10 not_eq, 11 eq
//   pc_write_cond  conditional PC write enable
//   pc_write       unconditional PC write enable
//   alu_src_a      1 = A register
//   alu_src_b      00 = B register
//   alu_op         010 = subtract, 000 otherwise
//   pc_source      01 = ALUOut (branch target), 10 = jump address
//   link_write     write PC to $31 (jal)
//   busy           high in any state other than IDLE
//   done           one-cycle completion pulse
//   illegal        one-cycle pulse for an unsupported opcode
//   branch_count   number of conditional branches resolved (wraps)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; captures opcode
// COMPARE | ALU computes A-B so the flags are ready for the condition mux
// RESOLVE | conditional PC write to branch target, done, count++
// LINK    | jal only: write return address to $31
// JUMP    | unconditional PC write to jump address, done
// ERR     | unsupported opcode: illegal + done, no PC write

module branch_ctrl_fsm #(
   parameter int OP_WIDTH  = 6,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [OP_WIDTH-1:0]  opcode,
   output logic [1:0]           branch_ctrl,
   output logic                 pc_write_cond,
   output logic                 pc_write,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [2:0]           alu_op,
   output logic [1:0]           pc_source,
   output logic                 link_write,
   output logic                 busy,
   output logic                 done,
   output logic                 illegal,
   output logic [CNT_WIDTH-1:0] branch_count
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COMPARE = 3'd1;
   localparam logic [2:0] S_RESOLVE = 3'd2;
   localparam logic [2:0] S_JUMP    = 3'd4;
   localparam logic [2:0] S_ERR     = 3'd5;
`ifdef BRANCH_JAL_EN
   localparam logic [2:0] S_LINK    = 3'd3;
   localparam logic [OP_WIDTH-1:0] OP_JAL = OP_WIDTH'(8'h03);
`endif

   localparam logic [OP_WIDTH-1:0] OP_J   = OP_WIDTH'(8'h02);
   localparam logic [OP_WIDTH-1:0] OP_BEQ = OP_WIDTH'(8'h04);
   localparam logic [OP_WIDTH-1:0] OP_BNE = OP_WIDTH'(8'h05);
   localparam logic [OP_WIDTH-1:0] OP_BLE = OP_WIDTH'(8'h06);
   localparam logic [OP_WIDTH-1:0] OP_BGT = OP_WIDTH'(8'h07);

   logic [2:0]           state;
   logic [2:0]           state_nxt;
   logic [OP_WIDTH-1:0]  opcode_q;
   logic [CNT_WIDTH-1:0] count_q;
   logic                 accept;
   logic                 is_branch;

   assign accept    = (state == S_IDLE) && start;
   assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                      (opcode == OP_BLE) || (opcode == OP_BGT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Only branch opcodes are captured, so branch_ctrl keeps its last branch
   // condition across jumps and illegal opcodes (pc_write_cond is 0 then).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opcode_q <= '0;
      end else if (accept && is_branch) begin
         opcode_q <= opcode;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (state == S_RESOLVE) begin
         count_q <= count_q + CNT_WIDTH'(1);
      end
   end

   assign branch_count = count_q;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (is_branch) begin
                  state_nxt = S_COMPARE;
               end else if (opcode == OP_J) begin
                  state_nxt = S_JUMP;
`ifdef BRANCH_JAL_EN
               end else if (opcode == OP_JAL) begin
                  state_nxt = S_LINK;
`endif
               end else begin
                  state_nxt = S_ERR;
               end
            end
         end
         S_COMPARE: state_nxt = S_RESOLVE;
         S_RESOLVE: state_nxt = S_IDLE;
`ifdef BRANCH_JAL_EN
         S_LINK:    state_nxt = S_JUMP;
`endif
         S_JUMP:    state_nxt = S_IDLE;
         S_ERR:     state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      pc_write_cond = 1'b0;
      pc_write      = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 3'b000;
      pc_source     = 2'b00;
      link_write    = 1'b0;
      done          = 1'b0;
      illegal       = 1'b0;
      busy          = (state != S_IDLE);
      case (state)
         S_COMPARE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b00;
            alu_op    = 3'b010;
         end
         S_RESOLVE: begin
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            done          = 1'b1;
         end
`ifdef BRANCH_JAL_EN
         S_LINK: begin
            link_write = 1'b1;
         end
`endif
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            done      = 1'b1;
         end
         S_ERR: begin
            illegal = 1'b1;
            done    = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (opcode_q)
         OP_BEQ:  branch_ctrl = 2'b11;
         OP_BNE:  branch_ctrl = 2'b10;
         OP_BLE:  branch_ctrl = 2'b01;
         OP_BGT:  branch_ctrl = 2'b00;
         default: branch_ctrl = 2'b00;
      endcase
   end

endmodule
